// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder: slice width and controller state codes.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple adder slice built from full_adder cells.
// It also exposes the carry into bit 3, which is needed for signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_adder_cin
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c4,
  output logic                c3
);
  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign c4 = c[NIBBLE_W];
  assign c3 = c[NIBBLE_W-1];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder that time-shares one 4-bit slice: one nibble per clock, LSB first,
// with valid/ready on both sides and the result held until it is taken.
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);
  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] s4;
  logic                c4;
  logic                c3;
  logic                accept;

  nibble_adder_cin u_slice (
    .a   (a_sh_q[NIBBLE_W-1:0]),
    .b   (b_sh_q[NIBBLE_W-1:0]),
    .cin (carry_q),
    .s   (s4),
    .c4  (c4),
    .c3  (c3)
  );

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_RUN: begin
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        sum_d   = {s4, sum_q[W-1:NIBBLE_W]};
        carry_d = c4;
        if (idx_q == IDX_LAST) begin
          ovf_d   = c4 ^ c3;
          cout_d  = c4;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    // Acceptance from IDLE or from DONE-with-handshake overrides the case above.
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      idx_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule
